// File: rtl/instruction_memory_fetch.sv
// Instruction memory with a valid/ready fetch port, configurable read latency,
// a word-write programming port and misaligned/out-of-range fault reporting.
module instruction_memory_fetch #(
    parameter int              WIDTH     = 32,
    parameter int              ADDR_W    = 32,
    parameter int              DEPTH     = 256,
    parameter int              LATENCY   = 1,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h00000013),
    parameter string           INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WIDTH-1:0]  prog_data,
    output logic [31:0]       fetch_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = ADDR_W - 2;
    localparam logic [IW:0] DEPTH_W = (IW + 1)'(DEPTH);
    localparam logic [2:0] LAT_LOAD = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_instr_q, rsp_instr_d;
    logic [1:0]       rsp_fault_q, rsp_fault_d;
    logic [31:0]      count_q, count_d;

    logic [IW-1:0]    req_idx;
    logic [IW-1:0]    prog_idx;
    logic             req_mis;
    logic             req_oor;
    logic             prog_oor;
    logic [WIDTH-1:0] rd_word;
    logic             unused_prog_lsb;

    assign req_idx         = req_addr[ADDR_W-1:2];
    assign prog_idx        = prog_addr[ADDR_W-1:2];
    assign req_mis         = |req_addr[1:0];
    assign req_oor         = {1'b0, req_idx} >= DEPTH_W;
    assign prog_oor        = {1'b0, prog_idx} >= DEPTH_W;
    assign rd_word         = mem_q[req_idx[AW-1:0]];
    assign unused_prog_lsb = ^prog_addr[1:0];

    assign req_ready   = (state_q == IDLE) && !prog_en && !reset;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_instr   = rsp_instr_q;
    assign rsp_fault   = rsp_fault_q;
    assign fetch_count = count_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_instr_d = rsp_instr_q;
        rsp_fault_d = rsp_fault_q;
        count_d     = count_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    // Word is sampled here so later writes cannot disturb it
                    rsp_instr_d = (req_mis || req_oor) ? NOP : rd_word;
                    rsp_fault_d = {req_oor, req_mis};
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_fault_q <= 2'b00;
            count_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_fault_q <= rsp_fault_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_en && !prog_oor) begin
            mem_q[prog_idx[AW-1:0]] <= prog_data;
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = NOP;
        end
    end

    if (LATENCY < 1 || LATENCY > 4) begin : g_lat_warn
        initial $display("instruction_memory_fetch: LATENCY=%0d outside 1..4", LATENCY);
    end

endmodule
